// File: rtl/dct_zigzag_buf.sv
// dct_zigzag_buf: gathers 8x8 blocks of signed DCT coefficients in raster order
// into a two-bank ping-pong buffer and replays each block in JPEG zigzag order,
// arithmetically right-shifted by QSHIFT, over a valid/ready output port.
module dct_zigzag_buf #(
  parameter int QSHIFT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       drop_err,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready
);

  // Raster index of the coefficient emitted at each zigzag position.
  localparam logic [5:0] ZZ_TABLE [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } state_t;

  // Both banks live in one array; the top address bit selects the bank.
  logic [7:0]        r_mem [128];

  logic              r_wbank;
  logic [5:0]        r_waddr;
  logic [1:0]        r_full;
  logic              r_rbank;
  logic [5:0]        r_rcnt;
  state_t            r_state;
  logic              r_dropErr;

  logic              w_accept;
  logic              w_fill;
  logic              w_xfer;
  logic              w_free;
  logic [1:0]        w_fullNext;
  logic [6:0]        w_raddr;
  logic signed [7:0] w_rdata;
  logic signed [7:0] w_quant;

  // The write bank is never the bank being read, because a bank stays full until drained.
  assign in_ready = ~r_full[r_wbank];
  assign w_accept = in_valid & in_ready;
  assign w_fill   = w_accept & (r_waddr == 6'd63);
  assign w_xfer   = (r_state == ST_STREAM) & out_ready;
  assign w_free   = w_xfer & (r_rcnt == 6'd63);

  // Next value of the bank-full flags; a fill and a free on the same edge always hit different banks.
  always_comb begin
    w_fullNext = r_full;
    if (w_fill) begin
      w_fullNext[r_wbank] = 1'b1;
    end
    if (w_free) begin
      w_fullNext[r_rbank] = 1'b0;
    end
  end

  // Coefficient storage, deliberately not reset so partial blocks simply get overwritten.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[{r_wbank, r_waddr}] <= in_data;
    end
  end

  // Write pointer walks 0..63 and hops to the other bank after the last coefficient.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wbank <= 1'b0;
      r_waddr <= 6'd0;
    end else if (w_accept) begin
      r_waddr <= r_waddr + 6'd1;
      if (w_fill) begin
        r_wbank <= ~r_wbank;
      end
    end
  end

  // Bank-full flags and the sticky overflow indicator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full    <= 2'b00;
      r_dropErr <= 1'b0;
    end else begin
      r_full <= w_fullNext;
      if (in_valid && !in_ready) begin
        r_dropErr <= 1'b1;
      end
    end
  end

  // Read FSM: streams the oldest full bank and chains straight into the next one when it is ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rbank <= 1'b0;
      r_rcnt  <= 6'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_full[r_rbank]) begin
            r_state <= ST_STREAM;
            r_rcnt  <= 6'd0;
          end
        end
        ST_STREAM: begin
          if (w_xfer) begin
            r_rcnt <= r_rcnt + 6'd1;
            if (r_rcnt == 6'd63) begin
              r_rbank <= ~r_rbank;
              if (!w_fullNext[~r_rbank]) begin
                r_state <= ST_IDLE;
              end
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output path is a combinational ROM lookup plus memory read, held steady by the frozen read counter.
  assign w_raddr   = {r_rbank, ZZ_TABLE[r_rcnt]};
  assign w_rdata   = r_mem[w_raddr];
  assign w_quant   = w_rdata >>> QSHIFT;

  assign out_valid = (r_state == ST_STREAM);
  assign out_data  = out_valid ? w_quant : 8'd0;
  assign out_last  = out_valid & (r_rcnt == 6'd63);
  assign drop_err  = r_dropErr;

endmodule

// File: tb/tb_dct_zigzag_buf.sv
// tb_dct_zigzag_buf: drives two instances (QSHIFT=0 and QSHIFT=2) with the same
// stream and scores both against a block-level reference model of the buffer.
module tb_dct_zigzag_buf;

  logic       clk;
  logic       rst;
  logic       inValid;
  logic [7:0] inData;
  logic       outReady;

  logic       inReady0, dropErr0, outValid0, outLast0;
  logic [7:0] outData0;
  logic       inReady2, dropErr2, outValid2, outLast2;
  logic [7:0] outData2;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [7:0] d0;
    logic [7:0] d2;
    logic       last;
  } exp_t;

  exp_t expQ[$];
  int   zzOrder [64];
  int   blk [64];
  int   blkCnt;
  int   fullCnt;
  int   drainCnt;
  bit   expDrop;
  bit   streaming;

  bit         stall;
  logic [7:0] stallD0, stallD2;
  logic       stallLast;

  dct_zigzag_buf #(.QSHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_data(inData),
    .in_ready(inReady0), .drop_err(dropErr0), .out_valid(outValid0),
    .out_data(outData0), .out_last(outLast0), .out_ready(outReady)
  );

  dct_zigzag_buf #(.QSHIFT(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_data(inData),
    .in_ready(inReady2), .drop_err(dropErr2), .out_valid(outValid2),
    .out_data(outData2), .out_last(outLast2), .out_ready(outReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: bump the counters and report any disagreement.
  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, driven just after the rising edge.
  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit r);
    @(posedge clk);
    #1;
    inValid  = v;
    inData   = d;
    outReady = r;
  endtask

  // Floor division by 2**q, i.e. quantization that rounds toward minus infinity.
  function automatic int floorShift(input int v, input int q);
    int d;
    int r;
    d = 1 << q;
    r = v / d;
    if ((v % d) != 0 && v < 0) r = r - 1;
    return r;
  endfunction

  // Reference model: counts buffered blocks, predicts handshakes and queues each finished block in zigzag order.
  always @(negedge clk) begin : modelProc
    bit   acc;
    bit   xfer;
    bit   blockDone;
    int   newFull;
    exp_t e;
    if (rst) begin
      blkCnt    = 0;
      fullCnt   = 0;
      drainCnt  = 0;
      expDrop   = 1'b0;
      streaming = 1'b0;
      expQ.delete();
    end else begin
      checkOutput("in_ready_q0", int'(inReady0), int'(fullCnt < 2));
      checkOutput("in_ready_q2", int'(inReady2), int'(fullCnt < 2));
      checkOutput("out_valid_q0", int'(outValid0), int'(streaming));
      checkOutput("out_valid_q2", int'(outValid2), int'(streaming));
      checkOutput("drop_err_q0", int'(dropErr0), int'(expDrop));
      checkOutput("drop_err_q2", int'(dropErr2), int'(expDrop));
      acc = inValid && (fullCnt < 2);
      if (inValid && !(fullCnt < 2)) expDrop = 1'b1;
      xfer      = streaming && outReady;
      newFull   = fullCnt;
      blockDone = 1'b0;
      if (acc) begin
        blk[blkCnt] = int'($signed(inData));
        blkCnt++;
        if (blkCnt == 64) begin
          for (int p = 0; p < 64; p++) begin
            e.d0   = 8'(floorShift(blk[zzOrder[p]], 0));
            e.d2   = 8'(floorShift(blk[zzOrder[p]], 2));
            e.last = (p == 63);
            expQ.push_back(e);
          end
          blkCnt = 0;
          newFull++;
        end
      end
      if (xfer) begin
        drainCnt++;
        if (drainCnt == 64) begin
          drainCnt  = 0;
          blockDone = 1'b1;
          newFull--;
        end
      end
      if (streaming) streaming = !(blockDone && newFull == 0);
      else streaming = (fullCnt > 0);
      fullCnt = newFull;
    end
  end

  // Monitor: pops the expected coefficient on every output transfer and checks stability while stalled.
  always @(negedge clk) begin : monitorProc
    exp_t e;
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        checkOutput("stall_data_q0", int'($signed(outData0)), int'($signed(stallD0)));
        checkOutput("stall_data_q2", int'($signed(outData2)), int'($signed(stallD2)));
        checkOutput("stall_last", int'(outLast0), int'(stallLast));
      end
      if (outValid0 && outReady) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_output", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("data_q0", int'($signed(outData0)), int'($signed(e.d0)));
          checkOutput("data_q2", int'($signed(outData2)), int'($signed(e.d2)));
          checkOutput("last_q0", int'(outLast0), int'(e.last));
          checkOutput("last_q2", int'(outLast2), int'(e.last));
        end
      end
      stall     = outValid0 && !outReady;
      stallD0   = outData0;
      stallD2   = outData2;
      stallLast = outLast0;
    end
  end

  // Directed scenarios followed by a randomized soak and a final drain.
  initial begin
    int idx;
    int quantVals [3];
    idx = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
          zzOrder[idx] = r * 8 + (s - r);
          idx++;
        end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
          zzOrder[idx] = r * 8 + (s - r);
          idx++;
        end
      end
    end

    rst      = 1'b1;
    inValid  = 1'b0;
    inData   = 8'd0;
    outReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", int'(inReady0), 1);
    checkOutput("reset_out_valid", int'(outValid0), 0);
    rst = 1'b0;

    $display("[TB] single block, raster-index data");
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 8'(i), 1'b1);
    repeat (70) applyStimulus(1'b0, 8'd0, 1'b1);

    $display("[TB] back-to-back blocks with coinciding free and fill");
    for (int i = 0; i < 192; i++) applyStimulus(1'b1, 8'($urandom), 1'b1);
    repeat (70) applyStimulus(1'b0, 8'd0, 1'b1);

    $display("[TB] backpressure with three blocks offered");
    for (int i = 0; i < 192; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
    repeat (200) applyStimulus(1'b0, 8'd0, 1'b1);

    $display("[TB] quantization blocks");
    quantVals = '{-5, 127, -128};
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 64; i++) applyStimulus(1'b1, 8'(quantVals[b]), 1'b1);
      repeat (70) applyStimulus(1'b0, 8'd0, 1'b1);
    end

    $display("[TB] reset in the middle of a block while streaming");
    for (int i = 0; i < 94; i++) applyStimulus(1'b1, 8'($urandom), 1'b1);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    inValid = 1'b0;
    #1;
    checkOutput("rst_out_valid_q0", int'(outValid0), 0);
    checkOutput("rst_out_data_q0", int'(outData0), 0);
    checkOutput("rst_out_last_q0", int'(outLast0), 0);
    checkOutput("rst_in_ready_q0", int'(inReady0), 1);
    checkOutput("rst_drop_err_q0", int'(dropErr0), 0);
    checkOutput("rst_out_valid_q2", int'(outValid2), 0);
    checkOutput("rst_in_ready_q2", int'(inReady2), 1);
    checkOutput("rst_drop_err_q2", int'(dropErr2), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 8'(i), 1'b1);
    repeat (70) applyStimulus(1'b0, 8'd0, 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
    end
    repeat (300) applyStimulus(1'b0, 8'd0, 1'b1);
    @(negedge clk);
    checkOutput("scoreboard_empty", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
